// File: rtl/cic_decim_n.sv
// rtl/cic_decim_n.sv - N-stage CIC decimator: runtime rate, comb delay M, output shift, valid/ready out, sticky overrun
// Build option CIC_ROUND_EN: round half up before the shift and saturate to OUT_W (default: truncate and wrap).
module cic_decim_n #(
    parameter int N          = 4,
    parameter int M          = 1,
    parameter int IN_W       = 1,
    parameter int R_MAX_LOG2 = 16,
    parameter int ACC_W      = IN_W + N * (R_MAX_LOG2 + 2),
    parameter int OUT_W      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [IN_W-1:0]  din,
    input  logic [15:0]      dec_rate,
    input  logic [5:0]       out_shift,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             ovr_clr
);

    logic signed [ACC_W-1:0] x_in;

    generate
        if (IN_W == 1) begin : g_pdm
            assign x_in = din[0] ? ACC_W'(1) : {ACC_W{1'b1}};
        end else begin : g_pcm
            assign x_in = {{(ACC_W-IN_W){din[IN_W-1]}}, din};
        end
    endgenerate

    // Pipelined cascade: each stage adds the previous stage's registered value,
    // so all adders are one level deep; modulo wrap is cancelled by the combs.
    logic signed [ACC_W-1:0] integ_q [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= '0;
            end
        end else if (din_valid) begin
            integ_q[0] <= integ_q[0] + x_in;
            for (int k = 1; k < N; k++) begin
                integ_q[k] <= integ_q[k] + integ_q[k-1];
            end
        end
    end

    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rate_m1_q, rate_m1_d;
    logic [15:0] rate_req;
    logic        period_end;
    logic        tick_q;

    always_comb begin
        rate_req   = (dec_rate <= 16'd1) ? 16'd0 : dec_rate - 16'd1;
        period_end = din_valid && (cnt_q == rate_m1_q);
        cnt_d      = cnt_q;
        rate_m1_d  = rate_m1_q;
        if (period_end) begin
            cnt_d     = '0;
            rate_m1_d = rate_req;
        end else if (din_valid) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rate_m1_q <= rate_req;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rate_m1_q <= rate_m1_d;
            tick_q    <= period_end;
        end
    end

    logic signed [ACC_W-1:0] cap_q;
    logic                    cap_vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            cap_vld_q <= tick_q;
            if (tick_q) begin
                cap_q <= integ_q[N-1];
            end
        end
    end

    logic signed [ACC_W-1:0] comb_q   [N];
    logic signed [ACC_W-1:0] dly_q    [N][M];
    logic signed [ACC_W-1:0] stage_in [N];
    logic [N-1:0]            comb_vld_q;
    logic [N-1:0]            stage_vld;

    always_comb begin
        stage_in[0]  = cap_q;
        stage_vld[0] = cap_vld_q;
        for (int k = 1; k < N; k++) begin
            stage_in[k]  = comb_q[k-1];
            stage_vld[k] = comb_vld_q[k-1];
        end
    end

    // Each comb advances its delay line only on its own valid, so the
    // differential delay is counted in output samples, never in clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            comb_vld_q <= '0;
            for (int k = 0; k < N; k++) begin
                comb_q[k] <= '0;
                for (int j = 0; j < M; j++) begin
                    dly_q[k][j] <= '0;
                end
            end
        end else begin
            comb_vld_q <= stage_vld;
            for (int k = 0; k < N; k++) begin
                if (stage_vld[k]) begin
                    comb_q[k]   <= stage_in[k] - dly_q[k][M-1];
                    dly_q[k][0] <= stage_in[k];
                    for (int j = 1; j < M; j++) begin
                        dly_q[k][j] <= dly_q[k][j-1];
                    end
                end
            end
        end
    end

    logic signed [ACC_W-1:0] comb_out;
    logic [OUT_W-1:0]        res;

    assign comb_out = comb_q[N-1];

`ifdef CIC_ROUND_EN
    logic signed [ACC_W:0] rnd_add;
    logic signed [ACC_W:0] rnd_sum;
    logic signed [ACC_W:0] shifted;
    logic                  fits;

    // One guard bit keeps the rounding add from overflowing before saturation.
    always_comb begin
        rnd_add = (out_shift == 6'd0) ? '0 : ((ACC_W+1)'(1) << (out_shift - 6'd1));
        rnd_sum = {comb_out[ACC_W-1], comb_out} + rnd_add;
        shifted = rnd_sum >>> out_shift;
        fits    = (&shifted[ACC_W:OUT_W-1]) || !(|shifted[ACC_W:OUT_W-1]);
        if (fits) begin
            res = shifted[OUT_W-1:0];
        end else if (shifted[ACC_W]) begin
            res = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        res = OUT_W'(comb_out >>> out_shift);
    end
`endif

    logic             new_word;
    logic             ovr_set;
    logic [OUT_W-1:0] out_data_q;
    logic             out_valid_q;
    logic             overrun_q;

    assign new_word = comb_vld_q[N-1];
    assign ovr_set  = new_word && out_valid_q && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (new_word) begin
                out_data_q  <= res;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            overrun_q <= ovr_set || (overrun_q && !ovr_clr);
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_decim_n.sv
// tb/tb_cic_decim_n.sv - self-checking bench for cic_decim_n (24-bit and 16-bit output instances)
module tb_cic_decim_n;

    localparam int N = 4;
    localparam int M = 1;
`ifdef CIC_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic [0:0]  din;
    logic [15:0] dec_rate;
    logic [5:0]  out_shift;
    logic        out_ready;
    logic        ovr_clr;
    logic [23:0] out_data24;
    logic [15:0] out_data16;
    logic        out_valid24, out_valid16;
    logic        overrun24, overrun16;

    always #5 clk = ~clk;

    cic_decim_n #(.N(N), .M(M), .IN_W(1), .OUT_W(24)) u_dut24 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .dec_rate(dec_rate),
        .out_shift(out_shift), .out_data(out_data24), .out_valid(out_valid24),
        .out_ready(out_ready), .overrun(overrun24), .ovr_clr(ovr_clr)
    );

    cic_decim_n #(.N(N), .M(M), .IN_W(1), .OUT_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .dec_rate(dec_rate),
        .out_shift(out_shift), .out_data(out_data16), .out_valid(out_valid16),
        .out_ready(out_ready), .overrun(overrun16), .ovr_clr(ovr_clr)
    );

    int     n_pass  = 0;
    int     n_total = 0;
    int     ecount  = 0;
    longint got24[$];
    longint got16[$];
    int     got_t[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecount);
    endtask

    function automatic longint binom(input int n, input int k);
        longint r;
        r = 1;
        if (k < 0 || n < k) return 0;
        for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
        return r;
    endfunction

    function automatic int eff_rate(input logic [15:0] r);
        return (r <= 16'd1) ? 1 : int'(r);
    endfunction

    function automatic longint reduce(input longint v, input int sh, input int w);
        longint t, mx;
`ifdef CIC_ROUND_EN
        if (sh > 0) v = v + (64'sd1 <<< (sh - 1));
        t  = v >>> sh;
        mx = (64'sd1 <<< (w - 1)) - 1;
        if (t > mx) t = mx;
        if (t < -mx - 1) t = -mx - 1;
`else
        t  = v >>> sh;
        mx = (64'sd1 <<< w) - 1;
        t  = t & mx;
        if (((t >>> (w - 1)) & 1) == 1) t = t - (64'sd1 <<< w);
`endif
        return t;
    endfunction

    // Model: the captured integrator value after sample n is sum x[j]*C(n-j, N-1);
    // the comb output is the N-th difference (step M) of the captured sequence.
    initial begin
        int     xs[$];
        longint caps[$];
        longint arr[int];
        int     m_cnt, m_rate, n, idx;
        longint cap, v;
        bit     e_valid, e_ovr, ovr_set;
        longint e_d24, e_d16;
        bit     s_rst, s_dv, s_din, s_ready, s_clr;
        logic [15:0] s_rate;
        int     s_shift;
        s_rst = 1'b1; s_dv = 1'b0; s_din = 1'b0; s_ready = 1'b1; s_clr = 1'b0;
        s_rate = 16'd16; s_shift = 0;
        m_cnt = 0; m_rate = 16; e_valid = 0; e_ovr = 0; e_d24 = 0; e_d16 = 0;
        forever begin
            @(negedge clk);
            ecount++;
            if (s_rst) begin
                xs.delete(); caps.delete(); arr.delete();
                m_cnt = 0; m_rate = eff_rate(s_rate);
                e_valid = 0; e_ovr = 0; e_d24 = 0; e_d16 = 0;
            end else begin
                ovr_set = 0;
                if (arr.exists(ecount)) begin
                    if (e_valid && !s_ready) ovr_set = 1;
                    e_valid = 1;
                    e_d24 = reduce(arr[ecount], s_shift, 24);
                    e_d16 = reduce(arr[ecount], s_shift, 16);
                    arr.delete(ecount);
                end else if (e_valid && s_ready) begin
                    e_valid = 0;
                end
                e_ovr = ovr_set || (e_ovr && !s_clr);
                if (s_dv) begin
                    xs.push_back(s_din ? 1 : -1);
                    m_cnt++;
                    if (m_cnt >= m_rate) begin
                        m_cnt  = 0;
                        m_rate = eff_rate(s_rate);
                        n   = xs.size() - 1;
                        cap = 0;
                        for (int j = 0; j <= n; j++) cap += xs[j] * binom(n - j, N - 1);
                        caps.push_back(cap);
                        idx = caps.size() - 1;
                        v   = 0;
                        for (int t = 0; t <= N; t++) begin
                            if (idx - t * M >= 0) begin
                                if (t % 2 == 0) v += binom(N, t) * caps[idx - t * M];
                                else            v -= binom(N, t) * caps[idx - t * M];
                            end
                        end
                        arr[ecount + N + 2] = v;
                    end
                end
            end
            s_rst = rst; s_dv = din_valid; s_din = din[0]; s_ready = out_ready;
            s_clr = ovr_clr; s_rate = dec_rate; s_shift = int'(out_shift);

            chk("out_valid24", out_valid24, e_valid);
            chk("out_valid16", out_valid16, e_valid);
            chk("overrun24", overrun24, e_ovr);
            chk("overrun16", overrun16, e_ovr);
            chk("out_data24", $signed(out_data24), e_d24);
            chk("out_data16", $signed(out_data16), e_d16);

            if (out_valid24 && out_ready) begin
                got24.push_back($signed(out_data24));
                got16.push_back($signed(out_data16));
                got_t.push_back(ecount);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d);
        din_valid = 1'b1;
        din       = d[0:0];
        tick();
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_log();
        got24.delete();
        got16.delete();
        got_t.delete();
    endtask

    initial begin
        int     lat;
        longint lat_data;
        rst = 1'b1; din_valid = 1'b0; din = 1'b0; dec_rate = 16'd16;
        out_shift = 6'd0; out_ready = 1'b1; ovr_clr = 1'b0;
        repeat (3) tick();
        chk("reset_valid", out_valid24, 0);
        chk("reset_data", $signed(out_data24), 0);
        chk("reset_overrun", overrun24, 0);
        rst = 1'b0;

        // DC gain, R=16: (16*1)^4 = 65536
        clear_log();
        repeat (160) send(1);
        repeat (N + 6) tick();
        chk("dc_count", got24.size(), 10);
        chk("dc_first", got24[0], 1820);
        chk("dc_word4", got24[4], 65536);
        chk("dc_word9", got24[9], 65536);
        chk("dc_spacing", got_t[9] - got_t[8], 16);

        // Alternating input is nulled by the comb zeros
        clear_log();
        repeat (80) begin
            send(1);
            send(0);
        end
        repeat (N + 6) tick();
        chk("alt_count", got24.size(), 10);
        chk("alt_word9", got24[9], 0);

        // Latency, R=8
        dec_rate = 16'd8;
        do_reset();
        repeat (8) send(1);
        lat = -1;
        lat_data = 0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (out_valid24 && lat < 0) begin
                lat = k;
                lat_data = $signed(out_data24);
            end
        end
        tick();
        chk("latency", lat, N + 2);
        chk("latency_data", lat_data, 70);

        // Backpressure and overrun, R=4
        dec_rate = 16'd4;
        do_reset();
        clear_log();
        out_ready = 1'b0;
        repeat (12) send(1);
        repeat (N + 4) tick();
        chk("bp_valid", out_valid24, 1);
        chk("bp_newest", $signed(out_data24), 221);
        chk("bp_newest16", $signed(out_data16), 221);
        chk("bp_overrun", overrun24, 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("bp_clr_overrun", overrun24, 0);
        chk("bp_clr_valid", out_valid24, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_drained", out_valid24, 0);
        chk("bp_transfers", got24.size(), 1);

        // Rate change 16 -> 32 mid-period
        dec_rate = 16'd16;
        do_reset();
        clear_log();
        repeat (8) send(1);
        dec_rate = 16'd32;
        repeat (72) send(1);
        repeat (N + 6) tick();
        chk("rate_count", got24.size(), 3);
        chk("rate_gap1", got_t[1] - got_t[0], 32);
        chk("rate_gap2", got_t[2] - got_t[1], 32);

        // Reset mid-operation (rate still 32 here)
        out_ready = 1'b0;
        repeat (70) send(1);
        chk("pre_rst_valid", out_valid24, 1);
        chk("pre_rst_overrun", overrun24, 1);
        dec_rate = 16'd16;
        rst = 1'b1;
        tick();
        chk("rst_valid", out_valid24, 0);
        chk("rst_overrun", overrun24, 0);
        chk("rst_data", $signed(out_data24), 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        clear_log();
        repeat (160) send(1);
        repeat (N + 6) tick();
        chk("rerun_count", got24.size(), 10);
        chk("rerun_first", got24[0], 1820);
        chk("rerun_word9", got24[9], 65536);

        // R=64: gain 2^24 overflows both output widths
        dec_rate = 16'd64;
        do_reset();
        clear_log();
        repeat (384) send(1);
        repeat (N + 6) tick();
        chk("sat_count", got24.size(), 6);
        chk("sat16_first", got16[0], ROUND ? 32767 : -19984);
        chk("sat24_first", got24[0], 635376);
        chk("sat16_word5", got16[5], ROUND ? 32767 : 0);
        chk("sat24_word5", got24[5], ROUND ? 8388607 : 0);

        // dec_rate=0 acts as R=1; shift by 1 of +-1
        dec_rate  = 16'd0;
        out_shift = 6'd1;
        do_reset();
        clear_log();
        repeat (12) send(1);
        repeat (12) send(0);
        repeat (N + 6) tick();
        chk("r1_count", got24.size(), 24);
        chk("shift_pos", got24[10], ROUND ? 1 : 0);
        chk("shift_pos16", got16[10], ROUND ? 1 : 0);
        chk("shift_neg", got24[20], ROUND ? 0 : -1);
        chk("shift_zero", got24[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
